// File: rtl/ber_pkg.sv
// Shared types and constant helpers for the bit-error-rate meter.
//   state_t : measurement FSM state (IDLE, RUN, SAT)
//   clog2   : ceiling log2, used for popcount and window-counter widths
//   cnt_max : all-ones value of a counter of the given width
package ber_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      SAT  = 2'd2
   } state_t;

   function automatic int unsigned clog2(input int unsigned value);
      int unsigned r;
      r = 0;
      for (int unsigned i = 0; i < 32; i++) begin
         if ((64'd1 << i) < 64'(value)) r = i + 1;
      end
      return r;
   endfunction

   function automatic logic [63:0] cnt_max(input int unsigned width);
      return (width >= 64) ? '1 : ((64'd1 << width) - 64'd1);
   endfunction

endpackage

// File: rtl/ber_popcount.sv
// Combinational mismatch counter: number of set bits in tx ^ rx.
//   tx, rx : compared words (DATA_W)
//   pop_c  : mismatched-bit count (clog2(DATA_W+1) bits, combinational)
module ber_popcount
   import ber_pkg::*;
#(
   parameter int unsigned DATA_W = 12
) (
   input  logic [DATA_W-1:0]              tx,
   input  logic [DATA_W-1:0]              rx,
   output logic [clog2(DATA_W + 1)-1:0]   pop_c
);

   localparam int unsigned POP_W = clog2(DATA_W + 1);

   logic [DATA_W-1:0] diff;

   assign diff = tx ^ rx;

   // Sum of single-bit terms; synthesis balances this into an adder tree.
   always_comb begin
      pop_c = '0;
      for (int unsigned i = 0; i < DATA_W; i++) begin
         pop_c = pop_c + POP_W'(diff[i]);
      end
   end

endmodule

// File: rtl/ber_meter.sv
// Bit-error-rate meter: two-stage compare/accumulate with saturating counters
// and optional fixed-length measurement windows.
//   clock, reset : rising-edge clock, asynchronous active-high reset
//   clear        : synchronous clear of everything (wins over enable)
//   enable       : sample valid
//   pattern_tx/rx: reference and received words (DATA_W)
//   errors, bits : running mismatched / compared bit counts (ERR_W)
//   win_errors   : error count latched at the close of the last window
//   win_done     : one-cycle pulse when win_errors updates
//   error_flag   : sticky saturation indicator
module ber_meter
   import ber_pkg::*;
#(
   parameter int unsigned DATA_W   = 12,
   parameter int unsigned ERR_W    = 50,
   parameter int unsigned WINDOW_N = 0
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              clear,
   input  logic              enable,
   input  logic [DATA_W-1:0] pattern_tx,
   input  logic [DATA_W-1:0] pattern_rx,
   output logic [ERR_W-1:0]  errors,
   output logic [ERR_W-1:0]  bits,
   output logic [ERR_W-1:0]  win_errors,
   output logic              win_done,
   output logic              error_flag
);

   localparam int unsigned POP_W = clog2(DATA_W + 1);
   localparam int unsigned SUM_W = ERR_W + 1;
   localparam int unsigned WIN_W = (WINDOW_N > 1) ? clog2(WINDOW_N) : 1;
   localparam logic [ERR_W-1:0] CNT_MAX  = ERR_W'(cnt_max(ERR_W));
   localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW_N - 1);

   state_t            state;
   state_t            state_nx;
   logic [POP_W-1:0]  pop_c;
   logic [POP_W-1:0]  d1;
   logic              v1;
   logic [WIN_W-1:0]  wcnt;
   logic [SUM_W-1:0]  err_sum;
   logic [SUM_W-1:0]  bits_sum;
   logic              sat_c;
   logic              accept_c;
   logic              win_close_c;

   ber_popcount #(.DATA_W(DATA_W)) u_popcount (
      .tx    (pattern_tx),
      .rx    (pattern_rx),
      .pop_c (pop_c)
   );

   // One extra carry bit exposes overflow of either accumulator.
   assign err_sum  = {1'b0, errors} + SUM_W'(d1);
   assign bits_sum = {1'b0, bits} + SUM_W'(DATA_W);
   assign sat_c    = err_sum[ERR_W] | bits_sum[ERR_W];

   // State register.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nx;
   end

   // Next-state logic; clear returns to IDLE from anywhere.
   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE:    if (v1) state_nx = sat_c ? SAT : RUN;
         RUN:     if (v1 && sat_c) state_nx = SAT;
         SAT:     state_nx = SAT;
         default: state_nx = IDLE;
      endcase
      if (clear) state_nx = IDLE;
   end

   // Control decode: samples count in IDLE and RUN; saturation beats window close.
   always_comb begin
      accept_c    = v1 && (state != SAT);
      win_close_c = 1'b0;
      if (WINDOW_N != 0) win_close_c = accept_c && !sat_c && (wcnt == WIN_LAST);
   end

   // Stage 1 capture, stage 2 accumulate, window bookkeeping.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         d1         <= '0;
         v1         <= 1'b0;
         errors     <= '0;
         bits       <= '0;
         win_errors <= '0;
         win_done   <= 1'b0;
         error_flag <= 1'b0;
         wcnt       <= '0;
      end else if (clear) begin
         d1         <= '0;
         v1         <= 1'b0;
         errors     <= '0;
         bits       <= '0;
         win_errors <= '0;
         win_done   <= 1'b0;
         error_flag <= 1'b0;
         wcnt       <= '0;
      end else begin
         d1       <= pop_c;
         v1       <= enable;
         win_done <= 1'b0;
         if (accept_c) begin
            if (sat_c) begin
               errors     <= err_sum[ERR_W] ? CNT_MAX : err_sum[ERR_W-1:0];
               bits       <= bits_sum[ERR_W] ? CNT_MAX : bits_sum[ERR_W-1:0];
               error_flag <= 1'b1;
            end else if (win_close_c) begin
               win_errors <= err_sum[ERR_W-1:0];
               errors     <= '0;
               bits       <= '0;
               wcnt       <= '0;
               win_done   <= 1'b1;
            end else begin
               errors <= err_sum[ERR_W-1:0];
               bits   <= bits_sum[ERR_W-1:0];
               if (WINDOW_N != 0) wcnt <= wcnt + WIN_W'(1);
            end
         end
      end
   end

endmodule

// File: tb/tb_ber_meter.sv
// Testbench for ber_meter: four instances (free-running 12b, 8b text, windowed 12b,
// narrow saturating 12b) driven from shared stimulus.
module tb_ber_meter;

   logic        clock  = 1'b0;
   logic        reset  = 1'b1;
   logic        clear  = 1'b0;
   logic        enable = 1'b0;
   logic [11:0] tx     = '0;
   logic [11:0] rx     = '0;

   logic [49:0] f_errors, f_bits, f_win_errors;
   logic        f_win_done, f_flag;
   logic [49:0] t_errors, t_bits, t_win_errors;
   logic        t_win_done, t_flag;
   logic [49:0] w_errors, w_bits, w_win_errors;
   logic        w_win_done, w_flag;
   logic [5:0]  s_errors, s_bits, s_win_errors;
   logic        s_win_done, s_flag;

   always #5 clock = ~clock;

   int unsigned cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   ber_meter #(.DATA_W(12), .ERR_W(50), .WINDOW_N(0)) u_free (
      .clock(clock), .reset(reset), .clear(clear), .enable(enable),
      .pattern_tx(tx), .pattern_rx(rx),
      .errors(f_errors), .bits(f_bits), .win_errors(f_win_errors),
      .win_done(f_win_done), .error_flag(f_flag));

   ber_meter #(.DATA_W(8), .ERR_W(50), .WINDOW_N(0)) u_text (
      .clock(clock), .reset(reset), .clear(clear), .enable(enable),
      .pattern_tx(tx[7:0]), .pattern_rx(rx[7:0]),
      .errors(t_errors), .bits(t_bits), .win_errors(t_win_errors),
      .win_done(t_win_done), .error_flag(t_flag));

   ber_meter #(.DATA_W(12), .ERR_W(50), .WINDOW_N(4)) u_win (
      .clock(clock), .reset(reset), .clear(clear), .enable(enable),
      .pattern_tx(tx), .pattern_rx(rx),
      .errors(w_errors), .bits(w_bits), .win_errors(w_win_errors),
      .win_done(w_win_done), .error_flag(w_flag));

   ber_meter #(.DATA_W(12), .ERR_W(6), .WINDOW_N(0)) u_sat (
      .clock(clock), .reset(reset), .clear(clear), .enable(enable),
      .pattern_tx(tx), .pattern_rx(rx),
      .errors(s_errors), .bits(s_bits), .win_errors(s_win_errors),
      .win_done(s_win_done), .error_flag(s_flag));

   typedef struct {
      logic        en;
      logic [11:0] tx;
      logic [11:0] rx;
      int unsigned pop;
   } vec_t;

   typedef struct {
      int unsigned due;
      logic [63:0] f_err;
      logic [63:0] f_bits;
      logic [63:0] w_err;
      logic [63:0] w_bits;
      logic [63:0] w_win;
      logic        w_done;
   } sb_t;

   sb_t         sb[$];
   int          checks = 0;
   int          errs   = 0;
   logic [63:0] m_err, m_bits, m_werr, m_wbits, m_wwin;
   int unsigned m_wcnt;
   logic        m_done;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic do_clear();
      clear = 1'b1;
      tick();
      clear = 1'b0;
   endtask

   // Reference model for u_free and u_win; result becomes visible two edges after drive.
   task automatic model_step(input logic en, input int unsigned pop);
      sb_t e;
      m_done = 1'b0;
      if (en) begin
         m_err  = m_err + 64'(pop);
         m_bits = m_bits + 64'd12;
         m_wcnt++;
         if (m_wcnt == 4) begin
            m_wwin  = m_werr + 64'(pop);
            m_werr  = '0;
            m_wbits = '0;
            m_wcnt  = 0;
            m_done  = 1'b1;
         end else begin
            m_werr  = m_werr + 64'(pop);
            m_wbits = m_wbits + 64'd12;
         end
      end
      e.due    = cyc + 2;
      e.f_err  = m_err;
      e.f_bits = m_bits;
      e.w_err  = m_werr;
      e.w_bits = m_wbits;
      e.w_win  = m_wwin;
      e.w_done = m_done;
      sb.push_back(e);
   endtask

   task automatic sb_check();
      sb_t e;
      while (sb.size() != 0 && sb[0].due == cyc) begin
         e = sb.pop_front();
         chk("sb_errors",       64'(f_errors),     e.f_err);
         chk("sb_bits",         64'(f_bits),       e.f_bits);
         chk("sb_free_win",     64'(f_win_errors), 64'd0);
         chk("sb_free_done",    64'(f_win_done),   64'd0);
         chk("sb_win_errors",   64'(w_errors),     e.w_err);
         chk("sb_win_bits",     64'(w_bits),       e.w_bits);
         chk("sb_win_latched",  64'(w_win_errors), e.w_win);
         chk("sb_win_done",     64'(w_win_done),   64'(e.w_done));
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t vec[12];
      int   pulses;

      vec[0]  = '{1'b1, 12'hFFF, 12'h000, 12};
      vec[1]  = '{1'b0, 12'h000, 12'h000, 0};
      vec[2]  = '{1'b1, 12'hA5A, 12'hA5A, 0};
      vec[3]  = '{1'b1, 12'h001, 12'h000, 1};
      vec[4]  = '{1'b1, 12'hF0F, 12'h0F0, 12};
      vec[5]  = '{1'b1, 12'h123, 12'h321, 2};
      vec[6]  = '{1'b1, 12'h800, 12'h000, 1};
      vec[7]  = '{1'b1, 12'h555, 12'hAAA, 12};
      vec[8]  = '{1'b0, 12'hFFF, 12'h000, 0};
      vec[9]  = '{1'b1, 12'h0F0, 12'h000, 4};
      vec[10] = '{1'b1, 12'h00F, 12'h00E, 1};
      vec[11] = '{1'b1, 12'h3C0, 12'h000, 4};

      // Reset state
      repeat (2) tick();
      chk("rst_errors",  64'(f_errors),     64'd0);
      chk("rst_bits",    64'(f_bits),       64'd0);
      chk("rst_win",     64'(w_win_errors), 64'd0);
      chk("rst_done",    64'(w_win_done),   64'd0);
      chk("rst_flag",    64'(s_flag),       64'd0);
      reset = 1'b0;
      tick();

      // Table pass with scoreboard
      do_clear();
      tick();
      m_err = '0; m_bits = '0; m_werr = '0; m_wbits = '0; m_wwin = '0;
      m_wcnt = 0; m_done = 1'b0;
      for (int i = 0; i < 12; i++) begin
         tx = vec[i].tx; rx = vec[i].rx; enable = vec[i].en;
         model_step(vec[i].en, vec[i].pop);
         tick();
         sb_check();
      end
      enable = 1'b0;
      for (int k = 0; k < 2; k++) begin
         model_step(1'b0, 0);
         tick();
         sb_check();
      end
      for (int k = 0; k < 4 && sb.size() != 0; k++) begin
         tick();
         sb_check();
      end
      chk("sb_drain", 64'(sb.size()), 64'd0);

      // Single enable latency
      do_clear();
      tx = 12'hFFF; rx = 12'h000; enable = 1'b1;
      tick();
      enable = 1'b0;
      chk("lat_one_edge", 64'(f_errors), 64'd0);
      tick();
      chk("lat_errors", 64'(f_errors), 64'd12);
      chk("lat_bits",   64'(f_bits),   64'd12);

      // 8-bit text channel, ten single-bit errors
      do_clear();
      tx = 12'h0A5; rx = 12'h0A4; enable = 1'b1;
      repeat (10) tick();
      enable = 1'b0;
      repeat (2) tick();
      chk("text_errors", 64'(t_errors), 64'd10);
      chk("text_bits",   64'(t_bits),   64'd80);
      chk("text_flag",   64'(t_flag),   64'd0);

      // Two back-to-back windows
      do_clear();
      tx = 12'h001; rx = 12'h000; enable = 1'b1;
      pulses = 0;
      for (int k = 0; k < 12; k++) begin
         if (k == 8) enable = 1'b0;
         tick();
         if (w_win_done) begin
            pulses++;
            chk("win_latched", 64'(w_win_errors), 64'd4);
         end
      end
      chk("win_pulses", 64'(pulses),   64'd2);
      chk("win_after",  64'(w_errors), 64'd0);
      chk("win_bits",   64'(w_bits),   64'd0);

      // Saturation at 6 bits
      do_clear();
      tx = 12'hFFF; rx = 12'h000; enable = 1'b1;
      repeat (5) tick();
      enable = 1'b0;
      repeat (2) tick();
      chk("sat_pre_errors", 64'(s_errors), 64'd60);
      chk("sat_pre_flag",   64'(s_flag),   64'd0);
      enable = 1'b1;
      tick();
      enable = 1'b0;
      repeat (2) tick();
      chk("sat_errors", 64'(s_errors), 64'd63);
      chk("sat_bits",   64'(s_bits),   64'd63);
      chk("sat_flag",   64'(s_flag),   64'd1);
      enable = 1'b1;
      repeat (3) tick();
      enable = 1'b0;
      repeat (2) tick();
      chk("sat_hold_errors", 64'(s_errors), 64'd63);
      chk("sat_hold_flag",   64'(s_flag),   64'd1);
      do_clear();
      chk("sat_clr_errors", 64'(s_errors), 64'd0);
      chk("sat_clr_bits",   64'(s_bits),   64'd0);
      chk("sat_clr_flag",   64'(s_flag),   64'd0);
      enable = 1'b1;
      tick();
      enable = 1'b0;
      repeat (2) tick();
      chk("sat_restart", 64'(s_errors), 64'd12);

      // Clear and enable together drop the sample
      do_clear();
      tx = 12'hFFF; rx = 12'h000; clear = 1'b1; enable = 1'b1;
      tick();
      clear = 1'b0; enable = 1'b0;
      repeat (3) tick();
      chk("clr_en_errors", 64'(f_errors), 64'd0);
      chk("clr_en_bits",   64'(f_bits),   64'd0);

      // Async reset mid-window
      do_clear();
      tx = 12'hFFF; rx = 12'h000; enable = 1'b1;
      repeat (6) tick();
      enable = 1'b0;
      repeat (2) tick();
      chk("pre_rst_win",    64'(w_win_errors), 64'd48);
      chk("pre_rst_errors", 64'(w_errors),     64'd24);
      #2 reset = 1'b1;
      #1;
      chk("arst_errors", 64'(w_errors),     64'd0);
      chk("arst_bits",   64'(w_bits),       64'd0);
      chk("arst_win",    64'(w_win_errors), 64'd0);
      chk("arst_done",   64'(w_win_done),   64'd0);
      #2 reset = 1'b0;
      tick();
      tx = 12'h001; rx = 12'h000; enable = 1'b1;
      pulses = 0;
      for (int k = 0; k < 7; k++) begin
         if (k == 4) enable = 1'b0;
         tick();
         if (w_win_done) begin
            pulses++;
            chk("post_rst_latched", 64'(w_win_errors), 64'd4);
         end
      end
      chk("post_rst_pulses", 64'(pulses),   64'd1);
      chk("post_rst_errors", 64'(w_errors), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errs);
      $finish;
   end

endmodule
